// File: rtl/egg_timer_countdown.sv
// MM:SS BCD countdown egg timer with LOAD/COUNT/DONE control and a buzzer drive.
// The alarm tone sounds for the first 30 seconds of DONE.
module egg_timer_countdown (
    input  logic       pulse_500Hz,
    input  logic       reset,
    input  logic       pulse_1Hz,
    input  logic       enable_load,
    input  logic       enable_timer_countdown,
    input  logic [3:0] load_second_ones,
    input  logic [3:0] load_second_tens,
    input  logic [3:0] load_minute_ones,
    input  logic [3:0] load_minute_tens,
    output logic [3:0] second_ones,
    output logic [3:0] second_tens,
    output logic [3:0] minute_ones,
    output logic [3:0] minute_tens,
    output logic       cook_time,
    output logic       alarm_tone
);

    typedef enum logic [1:0] {LOAD = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [4:0] ALARM_SECS = 5'd30;

    state_t     state_q, state_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       cook_time_q, cook_time_d;
    logic       alarm_tone_q, alarm_tone_d;
    logic [4:0] alarm_cnt_q, alarm_cnt_d;
    logic       is_zero;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_v);
        return (d > max_v) ? max_v : d;
    endfunction

    assign is_zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                     (min_ones_q == 4'd0) && (min_tens_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        min_ones_d  = min_ones_q;
        min_tens_d  = min_tens_q;
        alarm_cnt_d = alarm_cnt_q;

        if (enable_load || state_q == LOAD) begin
            sec_ones_d = clamp_digit(load_second_ones, 4'd9);
            sec_tens_d = clamp_digit(load_second_tens, 4'd5);
            min_ones_d = clamp_digit(load_minute_ones, 4'd9);
            min_tens_d = clamp_digit(load_minute_tens, 4'd5);
            state_d    = (!enable_load && enable_timer_countdown) ? COUNT : LOAD;
        end else if (state_q == COUNT) begin
            if (is_zero) begin
                state_d = DONE;
            end else if (enable_timer_countdown && pulse_1Hz) begin
                // Borrow ripples only through digits that are already zero.
                if (sec_ones_q != 4'd0) begin
                    sec_ones_d = sec_ones_q - 4'd1;
                end else begin
                    sec_ones_d = 4'd9;
                    if (sec_tens_q != 4'd0) begin
                        sec_tens_d = sec_tens_q - 4'd1;
                    end else begin
                        sec_tens_d = 4'd5;
                        if (min_ones_q != 4'd0) begin
                            min_ones_d = min_ones_q - 4'd1;
                        end else begin
                            min_ones_d = 4'd9;
                            min_tens_d = min_tens_q - 4'd1;
                        end
                    end
                end
                if (sec_ones_d == 4'd0 && sec_tens_d == 4'd0 &&
                    min_ones_d == 4'd0 && min_tens_d == 4'd0) begin
                    state_d = DONE;
                end
            end
        end else begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
            if (pulse_1Hz && alarm_cnt_q < ALARM_SECS) begin
                alarm_cnt_d = alarm_cnt_q + 5'd1;
            end
        end

        if (state_d == DONE && state_q != DONE) begin
            alarm_cnt_d = 5'd0;
        end

        cook_time_d  = (state_d == DONE);
        alarm_tone_d = (state_d == DONE && alarm_cnt_d < ALARM_SECS) ? ~alarm_tone_q : 1'b0;
    end

    always_ff @(posedge pulse_500Hz) begin
        if (reset) begin
            state_q      <= LOAD;
            sec_ones_q   <= 4'd0;
            sec_tens_q   <= 4'd0;
            min_ones_q   <= 4'd0;
            min_tens_q   <= 4'd0;
            cook_time_q  <= 1'b0;
            alarm_tone_q <= 1'b0;
            alarm_cnt_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            sec_ones_q   <= sec_ones_d;
            sec_tens_q   <= sec_tens_d;
            min_ones_q   <= min_ones_d;
            min_tens_q   <= min_tens_d;
            cook_time_q  <= cook_time_d;
            alarm_tone_q <= alarm_tone_d;
            alarm_cnt_q  <= alarm_cnt_d;
        end
    end

    assign second_ones = sec_ones_q;
    assign second_tens = sec_tens_q;
    assign minute_ones = min_ones_q;
    assign minute_tens = min_tens_q;
    assign cook_time   = cook_time_q;
    assign alarm_tone  = alarm_tone_q;

endmodule

// File: tb/tb_egg_timer_countdown.sv
// Directed bench for egg_timer_countdown: loads, borrow chain, pause, DONE alarm, reset.
module tb_egg_timer_countdown;

    logic       clk = 1'b0;
    logic       reset, pulse_1Hz, enable_load, enable_timer_countdown;
    logic [3:0] l_so, l_st, l_mo, l_mt;
    logic [3:0] so, st, mo, mt;
    logic       cook_time, alarm_tone;
    int         total = 0;
    int         bad = 0;
    logic       tone_a;

    egg_timer_countdown dut (
        .pulse_500Hz            (clk),
        .reset                  (reset),
        .pulse_1Hz              (pulse_1Hz),
        .enable_load            (enable_load),
        .enable_timer_countdown (enable_timer_countdown),
        .load_second_ones       (l_so),
        .load_second_tens       (l_st),
        .load_minute_ones       (l_mo),
        .load_minute_tens       (l_mt),
        .second_ones            (so),
        .second_tens            (st),
        .minute_ones            (mo),
        .minute_tens            (mt),
        .cook_time              (cook_time),
        .alarm_tone             (alarm_tone)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        pulse_1Hz = 1'b1;
        step();
        pulse_1Hz = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input logic [15:0] exp);
        chk(tag, {mt, mo, st, so}, exp);
    endtask

    task automatic set_load(input logic [15:0] v);
        {l_mt, l_mo, l_st, l_so} = v;
    endtask

    // Load a value with enable_load, then release it and start counting (LOAD -> COUNT).
    task automatic load_and_start(input logic [15:0] v);
        set_load(v);
        enable_load = 1'b1;
        enable_timer_countdown = 1'b0;
        step();
        enable_load = 1'b0;
        enable_timer_countdown = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1; pulse_1Hz = 1'b0; enable_load = 1'b0; enable_timer_countdown = 1'b0;
        set_load(16'h0000);
        step(); step();
        chk_digits("reset_digits", 16'h0000);
        chk("reset_cook", {15'd0, cook_time}, 16'd0);
        chk("reset_tone", {15'd0, alarm_tone}, 16'd0);

        // 01:00 countdown to 00:00
        reset = 1'b0;
        load_and_start(16'h0100);
        chk_digits("load_0100", 16'h0100);
        chk("count_cook", {15'd0, cook_time}, 16'd0);
        tick();
        chk_digits("tick1_0059", 16'h0059);
        for (int i = 0; i < 58; i++) tick();
        chk_digits("tick59_0001", 16'h0001);
        chk("pre_done_cook", {15'd0, cook_time}, 16'd0);
        tick();
        chk_digits("tick60_0000", 16'h0000);
        chk("done_cook_same_edge", {15'd0, cook_time}, 16'd1);
        chk("done_tone_entry", {15'd0, alarm_tone}, 16'd1);
        step();
        chk("done_tone_toggle0", {15'd0, alarm_tone}, 16'd0);
        step();
        chk("done_tone_toggle1", {15'd0, alarm_tone}, 16'd1);

        // Alarm: 29 ticks still toggling, 30th silences it
        for (int i = 0; i < 29; i++) tick();
        tone_a = alarm_tone;
        step();
        chk("tone_toggle_29", {15'd0, alarm_tone}, {15'd0, ~tone_a});
        chk_digits("done_hold_0000", 16'h0000);
        tick();
        chk("tone_off_30", {15'd0, alarm_tone}, 16'd0);
        step();
        chk("tone_stays_off", {15'd0, alarm_tone}, 16'd0);
        chk("done_cook_hold", {15'd0, cook_time}, 16'd1);

        // Leave DONE with enable_load, even with tick and countdown asserted
        set_load(16'h1000);
        enable_load = 1'b1;
        pulse_1Hz = 1'b1;
        step();
        pulse_1Hz = 1'b0;
        chk_digits("exit_done_digits", 16'h1000);
        chk("exit_done_cook", {15'd0, cook_time}, 16'd0);
        chk("exit_done_tone", {15'd0, alarm_tone}, 16'd0);
        enable_load = 1'b0;
        step();
        tick();
        chk_digits("borrow_chain_0959", 16'h0959);

        load_and_start(16'h0010);
        tick();
        chk_digits("tick_0009", 16'h0009);

        // 00:00 goes to DONE without a tick, two edges after countdown rises
        set_load(16'h0000);
        enable_load = 1'b1; enable_timer_countdown = 1'b0;
        step();
        enable_load = 1'b0; enable_timer_countdown = 1'b1;
        step();
        chk("zero_edge1_cook", {15'd0, cook_time}, 16'd0);
        step();
        chk("zero_edge2_cook", {15'd0, cook_time}, 16'd1);

        // Reset from DONE
        reset = 1'b1;
        step();
        chk("reset_in_done_cook", {15'd0, cook_time}, 16'd0);
        chk("reset_in_done_tone", {15'd0, alarm_tone}, 16'd0);
        reset = 1'b0;

        // Invalid BCD clamps to 09:59
        set_load(16'h0C7A);
        enable_load = 1'b1; enable_timer_countdown = 1'b0;
        step();
        chk_digits("clamp_0C7A", 16'h0959);
        set_load(16'h7F00);
        step();
        chk_digits("clamp_tens", 16'h5900);

        // Pause at 03:27, then resume, then reset mid-count
        load_and_start(16'h0327);
        enable_timer_countdown = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            step();
        end
        chk_digits("pause_0327", 16'h0327);
        enable_timer_countdown = 1'b1;
        tick();
        chk_digits("resume_0326", 16'h0326);
        reset = 1'b1;
        step();
        chk_digits("reset_mid_count", 16'h0000);
        chk("reset_mid_cook", {15'd0, cook_time}, 16'd0);

        // After reset, stays in LOAD (a zero value in COUNT would reach DONE)
        reset = 1'b0; enable_timer_countdown = 1'b0;
        set_load(16'h0000);
        for (int i = 0; i < 3; i++) tick();
        chk("post_reset_load_cook", {15'd0, cook_time}, 16'd0);
        chk_digits("post_reset_digits", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
